// File: rtl/game_sequencer_pkg.sv
// Shared game-flow definitions: state codes and BCD helper.
// State codes are also consumed by the HUD/text renderer.
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FIELD_RST  = 3'd1,
    S_PLAY       = 3'd2,
    S_WAVE_PAUSE = 3'd3,
    S_LIFE_LOST  = 3'd4,
    S_RESPAWN    = 3'd5,
    S_OVER       = 3'd6
  } state_t;

  localparam logic [11:0] SCORE_MAX = 12'h999;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (r[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (r[7:4] == 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = r[11:8] + 4'd1;
      end else begin
        r[7:4] = r[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = r[3:0] + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// 3-digit BCD score: increment, saturate at 999, sync clear.
module bcd_score_counter
  import game_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] bcd
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd <= 12'h000;
    end else if (clr) begin
      bcd <= 12'h000;
    end else if (inc && bcd != SCORE_MAX) begin
      bcd <= bcd_inc(bcd);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: attract/play/pause/over sequencing,
// control gating and HUD counters for the playfield.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int WAVE_SIZE    = 8,
  parameter int PAUSE_FRAMES = 60,
  parameter int OVER_FRAMES  = 120,
  parameter int BLINK_SHIFT  = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_shoot,
  input  logic        alien_hit,
  input  logic        aliens_down,
  output logic        field_reset,
  output logic        play_left,
  output logic        play_right,
  output logic        play_shoot,
  output logic [11:0] score_bcd,
  output logic [1:0]  lives,
  output logic [3:0]  wave,
  output logic [2:0]  state_o,
  output logic        banner_on
);

  localparam logic [1:0] LIVES0   = 2'(START_LIVES);
  localparam logic [8:0] WS       = 9'(WAVE_SIZE);
  localparam logic [7:0] PAUSE_M1 = 8'(PAUSE_FRAMES - 1);
  localparam logic [7:0] OVER_MIN = 8'(OVER_FRAMES);

  state_t st, ns;
  logic shoot_q, rise, reload, hit_en;
  logic [7:0] frm_cnt, hit_cnt;
  logic [8:0] hit_nxt;
  logic [BLINK_SHIFT:0] fcnt, fcnt_nx;

  assign rise    = btn_shoot & ~shoot_q;
  assign hit_en  = (st == S_PLAY) & alien_hit;
  assign hit_nxt = {1'b0, hit_cnt} + {8'd0, alien_hit};
  assign fcnt_nx = fcnt + {{BLINK_SHIFT{1'b0}}, frame_tick};

  always_comb begin
    ns     = st;
    reload = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (rise) begin
          ns     = S_FIELD_RST;
          reload = 1'b1;
        end
      end
      S_FIELD_RST: if (frame_tick) ns = S_PLAY;
      S_PLAY: begin
        if (aliens_down)
          ns = S_LIFE_LOST;
        else if (hit_nxt >= WS)
          ns = S_WAVE_PAUSE;
      end
      S_WAVE_PAUSE, S_RESPAWN: begin
        if (frame_tick && frm_cnt == PAUSE_M1)
          ns = S_FIELD_RST;
      end
      S_LIFE_LOST: ns = (lives == 2'd1) ? S_OVER : S_RESPAWN;
      S_OVER: begin
        if (rise && frm_cnt >= OVER_MIN) begin
          ns     = S_FIELD_RST;
          reload = 1'b1;
        end
      end
      default: ns = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      state_o     <= 3'd0;
      shoot_q     <= 1'b0;
      fcnt        <= '0;
      frm_cnt     <= 8'd0;
      hit_cnt     <= 8'd0;
      lives       <= 2'd0;
      wave        <= 4'd0;
      field_reset <= 1'b1;
      play_left   <= 1'b0;
      play_right  <= 1'b0;
      play_shoot  <= 1'b0;
      banner_on   <= 1'b1;
    end else begin
      st      <= ns;
      state_o <= ns;
      shoot_q <= btn_shoot;
      fcnt    <= fcnt_nx;
      if (ns != st)
        frm_cnt <= 8'd0;
      else if (frame_tick && frm_cnt != 8'hff)
        frm_cnt <= frm_cnt + 8'd1;
      if (reload) begin
        lives   <= LIVES0;
        wave    <= 4'd0;
        hit_cnt <= 8'd0;
      end else if (st == S_PLAY) begin
        // a kill that lands with aliens_down stays banked for the next round
        if (aliens_down)
          hit_cnt <= (hit_nxt >= WS) ? WS[7:0] : hit_nxt[7:0];
        else if (hit_nxt >= WS) begin
          hit_cnt <= 8'd0;
          wave    <= wave + 4'd1;
        end else
          hit_cnt <= hit_nxt[7:0];
      end else if (st == S_LIFE_LOST) begin
        lives <= lives - 2'd1;
      end
      field_reset <= (ns == S_IDLE) | (ns == S_FIELD_RST) | (ns == S_OVER);
      play_left   <= (ns == S_PLAY) & btn_left;
      play_right  <= (ns == S_PLAY) & btn_right;
      play_shoot  <= (ns == S_PLAY) & btn_shoot;
      banner_on   <= ((ns == S_IDLE) | (ns == S_OVER)) & ~fcnt_nx[BLINK_SHIFT];
    end
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (reload),
    .inc     (hit_en),
    .bcd     (score_bcd)
  );

endmodule
